// File: rtl/aes_share_driver.sv
// Splits plaintext/key into two Boolean shares, streams them byte-serially to a masked AES core
// and gathers the returned ciphertext shares. Optional watchdog enabled by SHARE_DRIVER_TIMEOUT_EN.
module aes_share_driver (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    input  logic [127:0] mask_pt,
    input  logic [127:0] mask_key,
    output logic         ready,
    output logic [7:0]   plain0,
    output logic [7:0]   plain1,
    output logic [7:0]   key0,
    output logic [7:0]   key1,
    output logic         pk_valid,
    input  logic         done_in,
    input  logic [7:0]   cipher0_in,
    input  logic [7:0]   cipher1_in,
    output logic [127:0] ct0,
    output logic [127:0] ct1,
    output logic         ct_valid,
    output logic         timeout
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_COLLECT, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0] pt_b [16];
    logic [7:0] key_b [16];
    logic [7:0] mpt_b [16];
    logic [7:0] mkey_b [16];
    logic [7:0] ptm_q [16];
    logic [7:0] ptm_d [16];
    logic [7:0] ptr_q [16];
    logic [7:0] ptr_d [16];
    logic [7:0] keym_q [16];
    logic [7:0] keym_d [16];
    logic [7:0] keyr_q [16];
    logic [7:0] keyr_d [16];
    logic [7:0] ct0_q [16];
    logic [7:0] ct0_d [16];
    logic [7:0] ct1_q [16];
    logic [7:0] ct1_d [16];
    logic [7:0] plain0_q, plain0_d, plain1_q, plain1_d;
    logic [7:0] key0_q, key0_d, key1_q, key1_d;
    logic       wd_hit;
    logic       store;

    assign cnt_inc = cnt_q + 4'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            assign pt_b[gi]               = pt[127-8*gi -: 8];
            assign key_b[gi]              = key[127-8*gi -: 8];
            assign mpt_b[gi]              = mask_pt[127-8*gi -: 8];
            assign mkey_b[gi]             = mask_key[127-8*gi -: 8];
            assign ct0[127-8*gi -: 8]     = ct0_q[gi];
            assign ct1[127-8*gi -: 8]     = ct1_q[gi];
        end
    endgenerate

`ifdef SHARE_DRIVER_TIMEOUT_EN
    logic [11:0] wd_q, wd_d;

    // Watchdog only runs while waiting on the core; every strobe restarts it.
    always_comb begin
        wd_d = '0;
        if ((state_q == S_WAIT || state_q == S_COLLECT) && !wd_hit && !done_in)
            wd_d = wd_q + 12'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end

    assign wd_hit  = (wd_q == 12'hFFF);
    assign timeout = wd_hit;
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                cnt_d = cnt_inc;
                if (cnt_q == 4'd15) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT, S_COLLECT: begin
                if (wd_hit) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (done_in) begin
                    state_d = S_COLLECT;
                    cnt_d   = cnt_inc;
                    if (cnt_q == 4'd15) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Status outputs
    always_comb begin
        ready    = (state_q == S_IDLE);
        pk_valid = (state_q == S_LOAD);
        ct_valid = (state_q == S_DONE);
    end

    assign store = (state_q == S_WAIT || state_q == S_COLLECT) && done_in && !wd_hit;

    // Byte 0 is loaded straight from the inputs so the first share byte appears one cycle after start.
    always_comb begin
        ptm_d    = ptm_q;
        ptr_d    = ptr_q;
        keym_d   = keym_q;
        keyr_d   = keyr_q;
        ct0_d    = ct0_q;
        ct1_d    = ct1_q;
        plain0_d = '0;
        plain1_d = '0;
        key0_d   = '0;
        key1_d   = '0;
        if (state_q == S_IDLE && start) begin
            for (int i = 0; i < 16; i++) begin
                ptm_d[i]  = pt_b[i] ^ mpt_b[i];
                ptr_d[i]  = mpt_b[i];
                keym_d[i] = key_b[i] ^ mkey_b[i];
                keyr_d[i] = mkey_b[i];
            end
            plain0_d = ptm_d[0];
            plain1_d = ptr_d[0];
            key0_d   = keym_d[0];
            key1_d   = keyr_d[0];
        end else if (state_q == S_LOAD && cnt_q != 4'd15) begin
            plain0_d = ptm_q[cnt_inc];
            plain1_d = ptr_q[cnt_inc];
            key0_d   = keym_q[cnt_inc];
            key1_d   = keyr_q[cnt_inc];
        end
        if (store) begin
            ct0_d[cnt_q] = cipher0_in;
            ct1_d[cnt_q] = cipher1_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            plain0_q <= '0;
            plain1_q <= '0;
            key0_q   <= '0;
            key1_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                ptm_q[i]  <= '0;
                ptr_q[i]  <= '0;
                keym_q[i] <= '0;
                keyr_q[i] <= '0;
                ct0_q[i]  <= '0;
                ct1_q[i]  <= '0;
            end
        end else begin
            plain0_q <= plain0_d;
            plain1_q <= plain1_d;
            key0_q   <= key0_d;
            key1_q   <= key1_d;
            ptm_q    <= ptm_d;
            ptr_q    <= ptr_d;
            keym_q   <= keym_d;
            keyr_q   <= keyr_d;
            ct0_q    <= ct0_d;
            ct1_q    <= ct1_d;
        end
    end

    assign plain0 = plain0_q;
    assign plain1 = plain1_q;
    assign key0   = key0_q;
    assign key1   = key1_q;

endmodule

// File: doc/aes_share_driver.md
AES_SHARE_DRIVER -- requirements
Module: aes_share_driver

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request to mask and send one block; sampled only when ready=1.
REQ-004 SHALL have port pt  input  128  unmasked plaintext; byte 0 = pt[127:120].
REQ-005 SHALL have port key  input  128  unmasked key; same byte order as pt.
REQ-006 SHALL have port mask_pt  input  128  fresh random mask for plaintext splitting.
REQ-007 SHALL have port mask_key  input  128  fresh random mask for key splitting.
REQ-008 SHALL have port ready  output  1  high in IDLE only.
REQ-009 SHALL have ports plain0, plain1, key0, key1  output  8 each  byte-serial shares to the masked AES core.
REQ-010 SHALL have port pk_valid  output  1  marks a valid share byte on plain0/plain1/key0/key1.
REQ-011 SHALL have port done_in  input  1  core output-byte strobe.
REQ-012 SHALL have ports cipher0_in, cipher1_in  input  8 each  ciphertext share bytes from the core.
REQ-013 SHALL have ports ct0, ct1  output  128 each  collected ciphertext shares; byte 0 in [127:120].
REQ-014 SHALL have port ct_valid  output  1  one-cycle pulse when ct0/ct1 are complete.
REQ-015 SHALL have port timeout  output  1  one-cycle pulse on watchdog expiry (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WAIT, COLLECT, DONE.
REQ-017 IDLE: start=1 SHALL capture pt^mask_pt, mask_pt, key^mask_key and mask_key into internal registers, clear the byte counter, and go to LOAD.
REQ-018 LOAD SHALL last exactly 16 cycles with pk_valid=1 and byte i on the outputs in cycle i.
REQ-019 In LOAD, plain0 SHALL equal byte i of pt^mask_pt, plain1 byte i of mask_pt, key0 byte i of key^mask_key, and key1 byte i of mask_key; all outputs registered.
REQ-020 pk_valid SHALL rise on the first clock edge after the start-sampling edge, so latency start-to-first-byte = 1 cycle.
REQ-021 After byte 15, the FSM SHALL enter WAIT with pk_valid=0 and the share outputs driven to 0.
REQ-022 WAIT and COLLECT: each cycle with done_in=1 SHALL store cipher0_in/cipher1_in into byte slot n of ct0/ct1 and increment n.
REQ-023 The first done_in in WAIT SHALL move the FSM to COLLECT; gaps in done_in SHALL hold n without error.
REQ-024 When the 16th byte (n=15) is stored, the FSM SHALL go to DONE; DONE SHALL pulse ct_valid for one cycle and then return to IDLE.
REQ-025 done_in SHALL be ignored in IDLE, LOAD and DONE; start SHALL be ignored outside IDLE.
REQ-026 ct0/ct1 SHALL hold their values until the next COLLECT overwrites them; the block SHALL never recombine shares internally.
REQ-027 The 4-bit byte counter SHALL wrap only through explicit clearing on state entry, never by overflow into the next phase.

Reset
REQ-028 rst=1 SHALL force IDLE, ready=1, pk_valid=0, ct_valid=0, timeout=0, and all share outputs, ct0, ct1 and internal registers to 0, including mid-LOAD or mid-COLLECT.
REQ-029 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-030 With SHARE_DRIVER_TIMEOUT_EN defined, a 12-bit watchdog SHALL count cycles in WAIT and COLLECT and restart at 0 on every done_in.
REQ-031 With SHARE_DRIVER_TIMEOUT_EN defined, reaching 4095 SHALL pulse timeout for one cycle and return the FSM to IDLE without asserting ct_valid.
REQ-032 Without SHARE_DRIVER_TIMEOUT_EN, the watchdog SHALL be absent, timeout SHALL be constant 0, and the FSM SHALL wait indefinitely.

Verification
REQ-033 Zero masks: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, start for one cycle -> 16 pk_valid cycles, plain0 bytes 00,11,...,ff, plain1=00, key0 bytes 00..0f.
REQ-034 Masks mask_pt=mask_key=all A5 -> plain0^plain1 and key0^key1 reproduce pt/key byte-for-byte; plain1=key1=A5 every valid cycle.
REQ-035 Core model drives 16 done_in cycles, with cipher0_in^cipher1_in = 69c4e0d86a7b0430d8cdb78070b4c55a and a 3-cycle gap after byte 7 -> single ct_valid; ct0^ct1 equals that value.
REQ-036 rst at LOAD byte 5 -> next cycle: IDLE, pk_valid=0, all outputs 0; a subsequent start runs a full 16-byte LOAD.
REQ-037 start pulsed during LOAD and done_in pulsed during LOAD -> both ignored; byte sequence and the later collection are unaffected.
REQ-038 With SHARE_DRIVER_TIMEOUT_EN, no done_in after LOAD -> timeout pulses 4095 cycles after WAIT entry, ready=1 next cycle, ct_valid never asserted.
